// File: rtl/dmem_pkg.sv
// Shared types and default sizes for the data-memory DMA copier.
package dmem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } dma_state_t;

endpackage

// File: rtl/dmem_dma.sv
// Word-by-word memory copier: one READ + one WRITE cycle per word, done pulse in cycle 2*len+1.
// No backpressure: the memory is assumed always ready; start is ignored unless idle.
module dmem_dma
  import dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              DMA_clk,
  input  logic              DMA_reset,
  input  logic              DMA_start,
  input  logic [ADDR_W-1:0] DMA_src,
  input  logic [ADDR_W-1:0] DMA_dst,
  input  logic [ADDR_W:0]   DMA_len,
  output logic              DMA_busy,
  output logic              DMA_done,
  output logic [ADDR_W-1:0] DMA_mem_address,
  output logic [DATA_W-1:0] DMA_mem_data_out,
  output logic              DMA_mem_write,
  output logic              DMA_mem_read,
  input  logic [DATA_W-1:0] DMA_mem_data_in
);

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  dma_state_t        state, state_nxt;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx;
  logic [DATA_W-1:0] buf_q;
  logic              last_word;

  // idx never exceeds len-1 <= 2^ADDR_W-1, so its low bits are the address offset.
  assign last_word = (idx == len_q - ONE);

  always_ff @(posedge DMA_clk) begin
    if (DMA_reset) begin
      state <= ST_IDLE;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      idx   <= '0;
      buf_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (DMA_start) begin
            src_q <= DMA_src;
            dst_q <= DMA_dst;
            len_q <= DMA_len;
            idx   <= '0;
          end
        end
        ST_READ:  buf_q <= DMA_mem_data_in;
        ST_WRITE: if (!last_word) idx <= idx + ONE;
        default:  ;
      endcase
    end
  end

  always_comb begin
    state_nxt        = state;
    DMA_busy         = 1'b0;
    DMA_done         = 1'b0;
    DMA_mem_read     = 1'b0;
    DMA_mem_write    = 1'b0;
    DMA_mem_address  = '0;
    DMA_mem_data_out = '0;
    case (state)
      ST_IDLE: begin
        if (DMA_start) state_nxt = (DMA_len == '0) ? ST_DONE : ST_READ;
      end
      ST_READ: begin
        DMA_busy        = 1'b1;
        DMA_mem_read    = 1'b1;
        DMA_mem_address = src_q + idx[ADDR_W-1:0];
        state_nxt       = ST_WRITE;
      end
      ST_WRITE: begin
        DMA_busy         = 1'b1;
        DMA_mem_write    = 1'b1;
        DMA_mem_address  = dst_q + idx[ADDR_W-1:0];
        DMA_mem_data_out = buf_q;
        state_nxt        = last_word ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        DMA_done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
